// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: opcodes and instruction field extraction shared by the pipelined CPU.
package cpu_param_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_LD   = 3'd5;
    localparam logic [2:0] OP_ST   = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Instructions are passed zero-extended to 32 bits; callers narrow the result.
    function automatic logic [2:0] f_op(input logic [31:0] instr, input int ra_w);
        return instr[3*ra_w +: 3];
    endfunction

    // slot 2 = rd, 1 = rs, 0 = rt
    function automatic logic [31:0] f_reg(input logic [31:0] instr, input int ra_w, input int slot);
        return (instr >> (slot * ra_w)) & ((32'd1 << ra_w) - 32'd1);
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] instr, input int ra_w);
        return instr & ((32'd1 << (2 * ra_w)) - 32'd1);
    endfunction

endpackage

// File: rtl/pipe_alu.sv
// pipe_alu: combinational ALU for ADD/SUB/AND/LDI; LDI passes the immediate on i_b.
module pipe_alu
    import cpu_param_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_we
);

    assign o_result = (i_op == OP_ADD) ? i_a + i_b :
                      (i_op == OP_SUB) ? i_a - i_b :
                      (i_op == OP_AND) ? i_a & i_b : i_b;
    assign o_we = (i_op == OP_ADD) || (i_op == OP_SUB) || (i_op == OP_AND) || (i_op == OP_LDI);

endmodule

// File: rtl/pipe_cpu_param.sv
// pipe_cpu_param: 4-stage in-order CPU (IF, ID, EX, WB) with full forwarding and HALT.
// Stage registers: r_if (fetched word), r_id (decode), r_ex (operands), r_wb (retire).
module pipe_cpu_param
    import cpu_param_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREG       = 4,
    parameter  int IMEM_DEPTH = 16,
    parameter  int DMEM_DEPTH = 16,
    localparam int RA_W       = $clog2(NREG),
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int DA_W       = $clog2(DMEM_DEPTH),
    localparam int INSTR_W    = 3 + 3 * RA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    input  logic               dmem_we,
    input  logic [DA_W-1:0]    dmem_waddr,
    input  logic [DATA_W-1:0]  dmem_wdata,
    input  logic [RA_W-1:0]    dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               retire_valid,
    output logic               retire_we,
    output logic [RA_W-1:0]    retire_rd,
    output logic [DATA_W-1:0]  retire_data,
    output logic               halted
);

    logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];
    logic [DATA_W-1:0]  r_rf   [NREG];

    logic [PC_W-1:0]    r_pc;
    logic               r_if_v, r_id_v, r_ex_v, r_wb_v, r_wb_we, r_stop, r_halted;
    logic [INSTR_W-1:0] r_if_instr, r_id_instr;
    logic [2:0]         r_ex_op, r_wb_op;
    logic [RA_W-1:0]    r_ex_rd, r_ex_rs, r_ex_rt, r_wb_rd;
    logic [DATA_W-1:0]  r_ex_a, r_ex_b, r_ex_imm, r_wb_data;

    logic [2:0]         w_id_op;
    logic [RA_W-1:0]    w_id_rd, w_id_rs, w_id_rt;
    logic [DATA_W-1:0]  w_id_a, w_id_b, w_id_imm;
    logic [DATA_W-1:0]  w_ex_a, w_ex_b, w_alu_b, w_alu_res, w_ex_data;
    logic [DA_W-1:0]    w_ex_addr;
    logic               w_alu_we, w_ex_we, w_ex_st, w_kill;

    assign w_id_op  = f_op(32'(r_id_instr), RA_W);
    assign w_id_rd  = RA_W'(f_reg(32'(r_id_instr), RA_W, 2));
    assign w_id_rs  = RA_W'(f_reg(32'(r_id_instr), RA_W, 1));
    assign w_id_rt  = RA_W'(f_reg(32'(r_id_instr), RA_W, 0));
    assign w_id_imm = DATA_W'(f_imm(32'(r_id_instr), RA_W));
    // ID reads see the value WB is writing this same cycle.
    assign w_id_a = (r_wb_we && r_wb_rd == w_id_rs) ? r_wb_data : r_rf[w_id_rs];
    assign w_id_b = (r_wb_we && r_wb_rd == w_id_rt) ? r_wb_data : r_rf[w_id_rt];

    assign w_ex_a    = (r_wb_we && r_wb_rd == r_ex_rs) ? r_wb_data : r_ex_a;
    assign w_ex_b    = (r_wb_we && r_wb_rd == r_ex_rt) ? r_wb_data : r_ex_b;
    assign w_alu_b   = (r_ex_op == OP_LDI) ? r_ex_imm : w_ex_b;
    assign w_ex_addr = DA_W'(w_ex_a);
    assign w_ex_data = (r_ex_op == OP_LD) ? r_dmem[w_ex_addr] : w_alu_res;
    assign w_ex_we   = w_alu_we || (r_ex_op == OP_LD);
    assign w_ex_st   = r_ex_v && (r_ex_op == OP_ST);
    // Once HALT reaches EX nothing younger may ever become valid again until reset.
    assign w_kill    = r_stop || (r_ex_v && r_ex_op == OP_HALT);

    pipe_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (r_ex_op),
        .i_a      (w_ex_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_res),
        .o_we     (w_alu_we)
    );

    always_ff @(posedge clk) begin
        if (rst && imem_we)
            r_imem[imem_waddr] <= imem_wdata;
        if (rst && dmem_we)
            r_dmem[dmem_waddr] <= dmem_wdata;
        else if (!rst && w_ex_st)
            r_dmem[w_ex_addr] <= w_ex_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= '0;
            r_if_v    <= 1'b0;
            r_id_v    <= 1'b0;
            r_ex_v    <= 1'b0;
            r_wb_v    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_op   <= OP_NOP;
            r_stop    <= 1'b0;
            r_halted  <= 1'b0;
            for (int i = 0; i < NREG; i++)
                r_rf[i] <= '0;
        end else begin
            if (!w_kill)
                r_pc <= r_pc + PC_W'(1);
            r_if_v     <= !w_kill;
            r_if_instr <= r_imem[r_pc];
            r_id_v     <= r_if_v && !w_kill;
            r_id_instr <= r_if_instr;
            r_ex_v     <= r_id_v && !w_kill;
            r_ex_op    <= w_id_op;
            r_ex_rd    <= w_id_rd;
            r_ex_rs    <= w_id_rs;
            r_ex_rt    <= w_id_rt;
            r_ex_a     <= w_id_a;
            r_ex_b     <= w_id_b;
            r_ex_imm   <= w_id_imm;
            r_wb_v     <= r_ex_v;
            r_wb_we    <= r_ex_v && w_ex_we;
            r_wb_rd    <= r_ex_rd;
            r_wb_data  <= w_ex_data;
            r_wb_op    <= r_ex_op;
            r_stop     <= w_kill;
            r_halted   <= r_halted || (r_wb_v && r_wb_op == OP_HALT);
            if (r_wb_we)
                r_rf[r_wb_rd] <= r_wb_data;
        end
    end

    assign pc           = r_pc;
    assign retire_valid = r_wb_v;
    assign retire_we    = r_wb_we;
    assign retire_rd    = r_wb_rd;
    assign retire_data  = r_wb_data;
    assign halted       = r_halted;
    assign dbg_rdata    = r_rf[dbg_raddr];

endmodule

// File: tb/tb_pipe_cpu_param.sv
// tb_pipe_cpu_param: scoreboard bench; an ISA-level interpreter predicts every retirement.
module tb_pipe_cpu_param;

    logic       clk = 1'b0, rst = 1'b1;
    logic       imem_we = 1'b0, dmem_we = 1'b0;
    logic [3:0] imem_waddr = '0, dmem_waddr = '0;
    logic [8:0] imem_wdata = '0;
    logic [7:0] dmem_wdata = '0;
    logic [1:0] dbg_raddr = '0;
    logic [7:0] dbg_rdata, retire_data;
    logic [3:0] pc;
    logic       retire_valid, retire_we, halted;
    logic [1:0] retire_rd;

    pipe_cpu_param dut (
        .clk(clk), .rst(rst),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
        .retire_valid(retire_valid), .retire_we(retire_we), .retire_rd(retire_rd),
        .retire_data(retire_data), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic       we;
        logic [1:0] rd;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    exp_t       mx;
    int         checks = 0, passes = 0, edge_n = -1;
    logic [8:0] prog [16];
    logic [7:0] dmi  [16];
    logic [7:0] mrf  [4];

    // edge_n = index of the most recent rising edge since reset was released
    always @(posedge clk) edge_n <= rst ? -1 : edge_n + 1;

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [1:0] rd, rs, rt);
        return {op, rd, rs, rt};
    endfunction

    function automatic logic [8:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {3'd4, rd, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Monitor: every retirement must match the next predicted one, at the predicted cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (retire_valid) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_retire at edge %0d: we=%0b rd=%0d data=0x%02h",
                             edge_n, retire_we, retire_rd, retire_data);
                end else begin
                    mx = q.pop_front();
                    if (retire_we !== mx.we || edge_n != mx.e ||
                        (mx.we && (retire_rd !== mx.rd || retire_data !== mx.data)))
                        $display("FAIL retire: got we=%0b rd=%0d data=0x%02h edge=%0d, expected we=%0b rd=%0d data=0x%02h edge=%0d",
                                 retire_we, retire_rd, retire_data, edge_n, mx.we, mx.rd, mx.data, mx.e);
                    else passes++;
                end
            end else if (q.size() > 0 && q[0].e <= edge_n) begin
                checks++;
                $display("FAIL missing_retire: got none at edge %0d, expected one due at edge %0d", edge_n, q[0].e);
                void'(q.pop_front());
            end
        end
    end

    // Sequential ISA interpreter: instruction s retires three edges after it is fetched at edge s.
    task automatic model_run(input int max_n);
        logic [7:0] rf [4];
        logic [7:0] dm [16];
        logic [8:0] w;
        logic [2:0] op;
        logic [1:0] rd, rs, rt;
        logic [7:0] a, b, v;
        int         p;
        exp_t       x;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        for (int i = 0; i < 16; i++) dm[i] = dmi[i];
        p = 0;
        for (int s = 0; s < max_n; s++) begin
            w  = prog[p];
            op = w[8:6]; rd = w[5:4]; rs = w[3:2]; rt = w[1:0];
            a  = rf[rs]; b = rf[rt]; v = 8'h00;
            case (op)
                3'd1: v = a + b;
                3'd2: v = a - b;
                3'd3: v = a & b;
                3'd4: v = {4'h0, w[3:0]};
                3'd5: v = dm[a[3:0]];
                3'd6: dm[a[3:0]] = b;
                default: v = 8'h00;
            endcase
            x.e = s + 3; x.we = (op >= 3'd1 && op <= 3'd5); x.rd = rd; x.data = v;
            if (x.we) rf[rd] = v;
            q.push_back(x);
            if (op == 3'd7) break;
            p = (p + 1) % 16;
        end
        for (int i = 0; i < 4; i++) mrf[i] = rf[i];
    endtask

    task automatic load(input string t);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            imem_we = 1'b1; imem_waddr = 4'(i); imem_wdata = prog[i];
            dmem_we = 1'b1; dmem_waddr = 4'(i); dmem_wdata = dmi[i];
        end
        @(negedge clk); #1;
        imem_we = 1'b0; dmem_we = 1'b0;
        check({t, "_reset_state"}, 32'({pc, retire_valid, retire_we, retire_rd, retire_data, halted}), 0);
    endtask

    task automatic start(input int max_n);
        q.delete();
        model_run(max_n);
        rst = 1'b0;
    endtask

    task automatic finish_run(input string t, input bit halting, input int max_n);
        int         k;
        bit         ok;
        logic [3:0] p0;
        for (k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (q.size() == 0) break;
        end
        if (k == 300) begin
            checks++;
            $display("FAIL %s_timeout: got %0d retirements outstanding, expected 0", t, q.size());
        end
        if (halting) begin
            check({t, "_halted_at_retire"}, 32'(halted), 0);
            @(negedge clk); #1;
            check({t, "_halted_rise"}, 32'(halted), 1);
            p0 = pc; ok = 1'b1;
            repeat (20) begin
                @(negedge clk); #1;
                if (halted !== 1'b1 || pc !== p0) ok = 1'b0;
            end
            check({t, "_halt_hold_pc_frozen"}, 32'(ok), 1);
            for (int r = 0; r < 4; r++) begin
                dbg_raddr = 2'(r); #1;
                check($sformatf("%s_reg%0d", t, r), 32'(dbg_rdata), 32'(mrf[r]));
            end
        end else begin
            check({t, "_pc_wrap"}, 32'(pc), (max_n + 3) % 16);
        end
    endtask

    task automatic dbg_expect(input string t, input logic [1:0] r, input logic [7:0] v);
        dbg_raddr = r; #1;
        check(t, 32'(dbg_rdata), 32'(v));
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            prog[i] = 9'h000;
            dmi[i]  = 8'($urandom);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        // 1: back-to-back dependency through forwarding
        clear_prog();
        prog[0] = ldi(1, 5); prog[1] = ldi(2, 3); prog[2] = ins(3'd1, 3, 1, 2); prog[3] = ins(3'd7, 0, 0, 0);
        load("t1"); start(64); finish_run("t1", 1, 64);
        dbg_expect("t1_r3_is_8", 2'd3, 8'h08);
        // 2: SUB wraps, AND uses a distance-1 and a distance-3 operand
        clear_prog();
        prog[0] = ldi(1, 3); prog[1] = ldi(2, 5); prog[2] = ins(3'd2, 3, 1, 2);
        prog[3] = ins(3'd3, 0, 3, 1); prog[4] = ins(3'd7, 0, 0, 0);
        load("t2"); start(64); finish_run("t2", 1, 64);
        dbg_expect("t2_r3_is_fe", 2'd3, 8'hFE);
        dbg_expect("t2_r0_is_02", 2'd0, 8'h02);
        // 3: LD right after ST to the same address
        clear_prog();
        dmi[4] = 8'h11;
        prog[0] = ldi(1, 4); prog[1] = ldi(2, 4'hA); prog[2] = ins(3'd6, 0, 1, 2);
        prog[3] = ins(3'd5, 3, 1, 0); prog[4] = ins(3'd7, 0, 0, 0);
        load("t3"); start(64); finish_run("t3", 1, 64);
        dbg_expect("t3_r3_is_0a", 2'd3, 8'h0A);
        // 4: instruction after HALT must never retire
        clear_prog();
        prog[0] = ldi(1, 1); prog[1] = ins(3'd7, 0, 0, 0); prog[2] = ins(3'd1, 1, 1, 1);
        load("t4"); start(64); finish_run("t4", 1, 64);
        dbg_expect("t4_r1_is_1", 2'd1, 8'h01);
        // 5: NOPs only, pc wraps with uninterrupted retirement
        clear_prog();
        load("t5"); start(24); finish_run("t5", 0, 24);
        // 6: one-cycle reset pulse mid-program, then full re-execution
        clear_prog();
        prog[0] = ldi(1, 3); prog[1] = ldi(2, 5); prog[2] = ins(3'd2, 3, 1, 2); prog[3] = ins(3'd3, 0, 3, 1);
        prog[4] = ins(3'd1, 1, 1, 2); prog[5] = ldi(2, 7); prog[6] = ins(3'd1, 3, 3, 2); prog[7] = ins(3'd7, 0, 0, 0);
        load("t6"); start(64);
        repeat (6) begin @(negedge clk); #1; end
        rst = 1'b1;
        @(negedge clk); #1;
        check("t6_pulse_retire_valid", 32'(retire_valid), 0);
        check("t6_pulse_pc", 32'(pc), 0);
        for (int r = 0; r < 4; r++) dbg_expect($sformatf("t6_pulse_reg%0d", r), 2'(r), 8'h00);
        start(64); finish_run("t6", 1, 64);
        // randomized straight-line programs ending in HALT
        for (int t = 0; t < 8; t++) begin
            int len;
            clear_prog();
            len = $urandom_range(3, 14);
            for (int i = 0; i < len; i++)
                prog[i] = ins(3'($urandom_range(0, 6)), 2'($urandom), 2'($urandom), 2'($urandom));
            prog[len] = ins(3'd7, 0, 0, 0);
            load($sformatf("rnd%0d", t)); start(64); finish_run($sformatf("rnd%0d", t), 1, 64);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_cpu_param.md
# pipe_cpu_param

Parametrised 4-stage in-order pipelined CPU (IF, ID, EX, WB) for the pipeline-processor line. It is the successor to the fixed 8-bit, 4-register core, with:
- configurable data width, register count and memory depths;
- full operand forwarding, so dependent back-to-back instructions never stall;
- store, immediate and HALT instructions;
- a retire/debug observation port for the bench.

## Interface
- DATA_W, 8: datapath and register width.
- NREG, 4: register count, power of 2, ≥2. RA_W = $clog2(NREG).
- IMEM_DEPTH, 16: instruction words, power of 2. PC_W = $clog2(IMEM_DEPTH).
- DMEM_DEPTH, 16: data words, power of 2. DA_W = $clog2(DMEM_DEPTH).
- Derived: INSTR_W = 3 + 3*RA_W. Fields, MSB first: op[3], rd[RA_W], rs[RA_W], rt[RA_W].

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_we / imem_waddr / imem_wdata  in  1 / PC_W / INSTR_W  program load; honoured only while rst=1.
- dmem_we / dmem_waddr / dmem_wdata  in  1 / DA_W / DATA_W  data preload; honoured only while rst=1.
- dbg_raddr  in  RA_W  debug register select.
- dbg_rdata  out  DATA_W  combinational regfile[dbg_raddr] (post-write array, no bypass).
- pc  out  PC_W  current fetch address.
- retire_valid  out  1  WB stage holds a real (non-squashed) instruction.
- retire_we  out  1  that instruction writes rd.
- retire_rd  out  RA_W  destination register.
- retire_data  out  DATA_W  value being written.
- halted  out  1  sticky; set after HALT retires.

## Operation
Opcodes:
- 000 NOP.
- 001 ADD: rd = rs + rt.
- 010 SUB: rd = rs − rt.
- 011 AND: rd = rs & rt.
- 100 LDI: rd = zero-extend({rs,rt}), truncated to DATA_W if wider.
- 101 LD: rd = dmem[reg[rs][DA_W-1:0]].
- 110 ST: dmem[reg[rs][DA_W-1:0]] = reg[rt].
- 111 HALT.

Arithmetic and addressing:
- All arithmetic is modulo 2^DATA_W.
- Memory addresses use the low DA_W bits of the register value (wrap).

Stages:
- IF: read imem[pc]; pc increments modulo IMEM_DEPTH.
- ID: read regfile. Same-cycle WB write to the same register is bypassed.
- EX: operands are forwarded with priority WB-stage result, then regfile. dmem read is asynchronous; ST writes at the end of the EX cycle.
- WB: regfile write of rd when retire_we=1.

Retire signals:
- retire_we = 1 for ADD, SUB, AND, LDI, LD.
- NOP, ST and HALT retire with retire_valid=1, retire_we=0.

HALT (detected in EX):
- Squash the IF/ID and ID/EX slots (their valid bits go to 0).
- Freeze pc.
- Let HALT proceed to WB.
- halted rises the cycle after HALT retires and stays high until rst.

Reset behaviour:
- Clears pc, every pipeline valid bit, the regfile and halted.
- imem and dmem are not cleared.
- Reset mid-program discards all in-flight instructions; any in-flight ST does not write.

## Timing
- Reset values: pc=0, retire_valid=0, retire_we=0, retire_rd=0, retire_data=0, halted=0.
- The first rising edge with rst=0 fetches imem[0].
- The instruction fetched at edge n is visible on retire_* during the cycle after edge n+3. Its regfile write occurs at edge n+4.
- Throughput is one instruction per cycle, with no stalls.
- A dependent instruction immediately following its producer (distance 1 or 2) receives the forwarded value.
- LD immediately after ST to the same address returns the stored value.
- With HALT fetched at edge h: pc stops at h+2, retire_valid for HALT is high in the cycle after h+3, and halted=1 from edge h+4.

## Structure
- Package cpu_param_pkg holds:
  - opcode localparams (OP_NOP … OP_HALT);
  - the field-extract functions, parametrised by RA_W.
- Sub-module pipe_alu: combinational; op, a, b in; result and we out. It covers ADD/SUB/AND/LDI; LD and ST muxing stay in the top level.
- Top level holds: memories, regfile, stage registers with valid bits, forwarding muxes, halt control.

## Test plan
All scenarios use defaults: DATA_W=8, NREG=4, INSTR_W=9.
1. LDI r1,5; LDI r2,3; ADD r3,r1,r2 back-to-back → third retire shows rd=3, data=8. dbg_rdata(r3)=8 one cycle later.
2. LDI r1,3; LDI r2,5; SUB r3,r1,r2 → retire_data=0xFE. Then AND r0,r3,r1 → 0x02.
3. Preload dmem[4]=0x11. LDI r1,4; LDI r2,0x0A; ST [r1],r2; LD r3,[r1] → r3 retires 0x0A. ST retires with retire_we=0.
4. LDI r1,1; HALT; ADD r1,r1,r1 → ADD never retires (retire_valid=0). r1 stays 1; pc frozen; halted=1 and stays high for 20 cycles.
5. Sixteen NOPs, no HALT → pc wraps 15→0 and retire_valid stays high continuously.
6. Pulse rst for one cycle mid-program → next cycle retire_valid=0, all registers 0. Program re-executes from pc=0 with the expected results.
